// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and helpers for clock-period monitors
package clk_mon_pkg;

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} mon_state_t;

    // Widest counter supported; narrower monitors slice their saturation value from this.
    localparam int MON_MAX_W = 32;
    localparam logic [MON_MAX_W-1:0] CNT_SAT_ALL = '1;

    function automatic logic [MON_MAX_W:0] abs_diff(input logic [MON_MAX_W:0] a,
                                                    input logic [MON_MAX_W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// rtl/clk_edge_det.sv - registered-history edge detector for a clk-synchronous divided clock
module clk_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_div_clk,
    output logic o_rise,
    output logic o_fall
);

    logic r_div_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_q <= 1'b0;
        end else begin
            r_div_q <= i_div_clk;
        end
    end

    // Combinational against the registered copy so the edge is seen in the cycle it happens.
    assign o_rise = i_div_clk & ~r_div_q;
    assign o_fall = ~i_div_clk & r_div_q;

endmodule

// File: rtl/clk_period_mon.sv
// rtl/clk_period_mon.sv - divided-clock high/low phase monitor; CLK_MON_MINMAX_EN adds period min/max
module clk_period_mon
    import clk_mon_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TOL   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_clk,
    input  logic [CNT_W-1:0] exp_half,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             mismatch,
    output logic             stuck_err,
    output logic             ovr_err
`ifdef CLK_MON_MINMAX_EN
    ,
    output logic [CNT_W:0]   per_min,
    output logic [CNT_W:0]   per_max
`endif
);

    localparam logic [CNT_W-1:0]   W_SAT = CNT_SAT_ALL[CNT_W-1:0];
    localparam logic [MON_MAX_W:0] W_TOL = (MON_MAX_W+1)'(TOL);

    mon_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi;
    logic             w_rise, w_fall, w_sat;
    logic             w_pub, w_stuck, w_hi_ld, w_load, w_mis;
    logic [MON_MAX_W:0] w_hi_x, w_lo_x, w_exp_x;

    clk_edge_det u_edge (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_div_clk (div_clk),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_sat = (r_cnt == W_SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_rise || w_fall) begin
            r_cnt <= CNT_W'(1);
        end else if (!w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pub       = 1'b0;
        w_stuck     = 1'b0;
        w_hi_ld     = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ARM;
                ARM:  if (w_rise) w_state_nxt = HIGH;
                HIGH: begin
                    if (w_sat) begin
                        w_state_nxt = ARM;
                        w_stuck     = 1'b1;
                    end else if (w_fall) begin
                        w_state_nxt = LOW;
                        w_hi_ld     = 1'b1;
                    end
                end
                LOW: begin
                    if (w_sat) begin
                        w_state_nxt = ARM;
                        w_stuck     = 1'b1;
                    end else if (w_rise) begin
                        // Closing rise also opens the next high phase.
                        w_state_nxt = HIGH;
                        w_pub       = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // A ready seen in the publish cycle retires the old result, making room for the new one.
    assign w_load  = w_pub & (~meas_valid | meas_ready);
    assign w_hi_x  = {{(MON_MAX_W+1-CNT_W){1'b0}}, r_hi};
    assign w_lo_x  = {{(MON_MAX_W+1-CNT_W){1'b0}}, r_cnt};
    assign w_exp_x = {{(MON_MAX_W+1-CNT_W){1'b0}}, exp_half};
    assign w_mis   = (abs_diff(w_hi_x, w_exp_x) > W_TOL) | (abs_diff(w_lo_x, w_exp_x) > W_TOL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hi       <= '0;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            mismatch   <= 1'b0;
            stuck_err  <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hi_ld) r_hi <= r_cnt;
            if (w_load) begin
                meas_valid <= 1'b1;
                high_cnt   <= r_hi;
                low_cnt    <= r_cnt;
                mismatch   <= w_mis;
            end else if (meas_ready) begin
                meas_valid <= 1'b0;
            end
            if (w_pub && !w_load) ovr_err   <= 1'b1;
            if (w_stuck)          stuck_err <= 1'b1;
        end
    end

`ifdef CLK_MON_MINMAX_EN
    logic [CNT_W:0] w_sum;
    assign w_sum = {1'b0, r_hi} + {1'b0, r_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_min <= '1;
            per_max <= '0;
        end else if (w_load) begin
            if (w_sum < per_min) per_min <= w_sum;
            if (w_sum > per_max) per_max <= w_sum;
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_mon.sv
// tb/tb_clk_period_mon.sv - directed self-checking bench for clk_period_mon (TOL=0 and TOL=1 instances)
module tb_clk_period_mon;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       div_clk;
    logic [7:0] exp_half;
    logic       meas_ready;

    logic       meas_valid0, mismatch0, stuck_err0, ovr_err0;
    logic [7:0] high_cnt0, low_cnt0;
    logic       meas_valid1, mismatch1, stuck_err1, ovr_err1;
    logic [7:0] high_cnt1, low_cnt1;
`ifdef CLK_MON_MINMAX_EN
    logic [8:0] per_min0, per_max0, per_min1, per_max1;
`endif

    int vectors = 0;
    int errs    = 0;

    clk_period_mon #(.CNT_W(8), .TOL(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_clk    (div_clk),
        .exp_half   (exp_half),
        .meas_valid (meas_valid0),
        .meas_ready (meas_ready),
        .high_cnt   (high_cnt0),
        .low_cnt    (low_cnt0),
        .mismatch   (mismatch0),
        .stuck_err  (stuck_err0),
        .ovr_err    (ovr_err0)
`ifdef CLK_MON_MINMAX_EN
        ,
        .per_min    (per_min0),
        .per_max    (per_max0)
`endif
    );

    clk_period_mon #(.CNT_W(8), .TOL(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_clk    (div_clk),
        .exp_half   (exp_half),
        .meas_valid (meas_valid1),
        .meas_ready (meas_ready),
        .high_cnt   (high_cnt1),
        .low_cnt    (low_cnt1),
        .mismatch   (mismatch1),
        .stuck_err  (stuck_err1),
        .ovr_err    (ovr_err1)
`ifdef CLK_MON_MINMAX_EN
        ,
        .per_min    (per_min1),
        .per_max    (per_max1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick(input logic d);
        div_clk = d;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_idle(input string tag, input logic d);
        tick(d);
        chk(tag, meas_valid0, 0);
    endtask

    task automatic period4_chk(input string tag);
        tick(1'b1);
        chk({tag, "_valid"}, meas_valid0, 1);
        chk({tag, "_high"},  high_cnt0,   2);
        chk({tag, "_low"},   low_cnt0,    2);
        chk({tag, "_mis"},   mismatch0,   0);
        tick(1'b1);
        chk({tag, "_drop"},  meas_valid0, 0);
        tick(1'b0);
        tick(1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        div_clk    = 1'b0;
        exp_half   = 8'd2;
        meas_ready = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("rst_valid", meas_valid0, 0);
        chk("rst_high",  high_cnt0,   0);
        chk("rst_low",   low_cnt0,    0);
        chk("rst_mis",   mismatch0,   0);
        chk("rst_stuck", stuck_err0,  0);
        chk("rst_ovr",   ovr_err0,    0);
`ifdef CLK_MON_MINMAX_EN
        chk("rst_pmin", per_min0, 9'h1FF);
        chk("rst_pmax", per_max0, 0);
`endif
        rst_n = 1'b1;
        en    = 1'b1;
        tick(1'b0);

        // divide-by-4: priming period produces nothing, then one result per period
        tick_idle("prime0", 1'b1);
        tick_idle("prime1", 1'b1);
        tick_idle("prime2", 1'b0);
        tick_idle("prime3", 1'b0);
        period4_chk("div4_a");
        period4_chk("div4_b");
        period4_chk("div4_c");

        // divide-by-6 with exp_half=2: mismatch at TOL=0, clean at TOL=1
        tick(1'b1);
        chk("div6_prev_valid", meas_valid0, 1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("div6_valid", meas_valid0, 1);
        chk("div6_high",  high_cnt0,   3);
        chk("div6_low",   low_cnt0,    3);
        chk("div6_mis0",  mismatch0,   1);
        chk("div6_mis1",  mismatch1,   0);
        chk("div6_high1", high_cnt1,   3);

        // stuck high: saturation at 255 flags error and re-arms
        for (int i = 0; i < 250; i++) tick(1'b1);
        chk("stuck_early", stuck_err0, 0);
        for (int i = 0; i < 10; i++) tick(1'b1);
        chk("stuck_set",   stuck_err0,  1);
        chk("stuck_set1",  stuck_err1,  1);
        chk("stuck_novld", meas_valid0, 0);
        tick_idle("resume0", 1'b0);
        tick_idle("resume1", 1'b1);
        tick_idle("resume2", 1'b1);
        tick_idle("resume3", 1'b0);
        tick_idle("resume4", 1'b0);
        tick(1'b1);
        chk("resume_valid", meas_valid0, 1);
        chk("resume_high",  high_cnt0,   2);
        chk("resume_low",   low_cnt0,    2);
        chk("resume_ovr",   ovr_err0,    0);
        chk("resume_stuck", stuck_err0,  1);

        // overrun: hold 2/2 result while a 3/3 period completes
        meas_ready = 1'b0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        chk("hold_valid", meas_valid0, 1);
        chk("hold_high",  high_cnt0,   2);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("ovr_valid", meas_valid0, 1);
        chk("ovr_high",  high_cnt0,   2);
        chk("ovr_low",   low_cnt0,    2);
        chk("ovr_mis",   mismatch0,   0);
        chk("ovr_set",   ovr_err0,    1);
        meas_ready = 1'b1;
        tick(1'b1);
        chk("ovr_accept", meas_valid0, 0);
        chk("ovr_sticky", ovr_err0,    1);

        // enable dropped mid-high: partial period must not publish
        en = 1'b0;
        tick_idle("en_off",  1'b1);
        en = 1'b1;
        tick_idle("en_on0",  1'b1);
        tick_idle("en_on1",  1'b0);
        tick_idle("en_on2",  1'b0);
        tick_idle("en_on3",  1'b1);
        tick_idle("en_on4",  1'b1);
        tick_idle("en_on5",  1'b0);
        tick_idle("en_on6",  1'b0);
        tick(1'b1);
        chk("en_valid", meas_valid0, 1);
        chk("en_high",  high_cnt0,   2);
        chk("en_low",   low_cnt0,    2);

        // reset in LOW with a pending result
        meas_ready = 1'b0;
        tick(1'b1);
        tick(1'b0);
        chk("pre_rst_valid", meas_valid0, 1);
`ifdef CLK_MON_MINMAX_EN
        chk("pre_rst_pmin", per_min0, 4);
        chk("pre_rst_pmax", per_max0, 6);
`endif
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", meas_valid0, 0);
        chk("mrst_high",  high_cnt0,   0);
        chk("mrst_low",   low_cnt0,    0);
        chk("mrst_stuck", stuck_err0,  0);
        chk("mrst_ovr",   ovr_err0,    0);
`ifdef CLK_MON_MINMAX_EN
        chk("mrst_pmin", per_min0, 9'h1FF);
        chk("mrst_pmax", per_max0, 0);
`endif
        rst_n      = 1'b1;
        meas_ready = 1'b1;
        tick(1'b0);
        tick_idle("rearm0", 1'b1);
        tick_idle("rearm1", 1'b1);
        tick_idle("rearm2", 1'b0);
        tick_idle("rearm3", 1'b0);
        period4_chk("post_a");
        period4_chk("post_b");
        period4_chk("post_c");
`ifdef CLK_MON_MINMAX_EN
        chk("post_pmin", per_min0, 4);
        chk("post_pmax", per_max0, 4);
`endif
        chk("post_ovr", ovr_err0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
